// File: rtl/dual_inst_queue_pkg.sv
// Shared widths and helpers for the dual-issue instruction queue.
// An entry is {pc[63:32], inst[31:0]}; the fetch and launch buses carry two entries.
package dual_inst_queue_pkg;

  localparam int ENTRY_W = 64;
  localparam int BUS_W   = 2 * ENTRY_W;

  // Number of entries launch actually retires this cycle. A double request
  // wins over a single one, and the request is clamped to what is present.
  function automatic logic [1:0] pop_count(input logic dbl,
                                           input logic sgl,
                                           input logic has_one,
                                           input logic has_two);
    logic [1:0] n;
    n = 2'd0;
    if (dbl && has_two) begin
      n = 2'd2;
    end else if ((dbl || sgl) && has_one) begin
      n = 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/dual_inst_queue_storage.sv
// Entry array for the instruction queue: two write ports used by the two
// fetch slots and two asynchronous read ports feeding line1/line2.
// The array is deliberately left unreset; validity is tracked by the count.
module iq_storage
  import dual_inst_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we0,
  input  logic [PTR_W-1:0]   waddr0,
  input  logic [ENTRY_W-1:0] wdata0,
  input  logic               we1,
  input  logic [PTR_W-1:0]   waddr1,
  input  logic [ENTRY_W-1:0] wdata1,
  input  logic [PTR_W-1:0]   raddr0,
  output logic [ENTRY_W-1:0] rdata0,
  input  logic [PTR_W-1:0]   raddr1,
  output logic [ENTRY_W-1:0] rdata1
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Both write ports always target different slots, so no collision handling
  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/dual_inst_queue.sv
// Two-wide circular instruction buffer between fetch and dual-issue launch.
// Head/tail/count control lives here; entries live in iq_storage.
module dual_inst_queue
  import dual_inst_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             line1_in_valid_i,
  input  logic             line2_in_valid_i,
  input  logic [BUS_W-1:0] in_bus_i,
  output logic             allowin_o,
  input  logic             double_lunch_i,
  input  logic             single_lunch_i,
  input  logic             zero_lunch_i,
  input  logic             excep_flush_i,
  input  logic             branch_flush_i,
  output logic             line1_out_valid_o,
  output logic             line2_out_valid_o,
  output logic [BUS_W-1:0] out_bus_o,
  output logic [PTR_W:0]   count_o
);

  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic               flush;
  logic               push_en;
  logic [1:0]         push_n;
  logic [1:0]         pop_n;
  logic [PTR_W-1:0]   slot2_addr;
  logic [PTR_W-1:0]   head_plus1;
  logic [ENTRY_W-1:0] rd_line1;
  logic [ENTRY_W-1:0] rd_line2;
  logic               zero_lunch_unused;

  assign zero_lunch_unused = zero_lunch_i;

  assign flush     = excep_flush_i | branch_flush_i;
  assign allowin_o = (count <= CNT_W'(DEPTH - 2));
  assign push_en   = allowin_o & ~flush;
  assign push_n    = push_en ? ({1'b0, line1_in_valid_i} + {1'b0, line2_in_valid_i}) : 2'd0;
  assign pop_n     = flush ? 2'd0 :
                     pop_count(double_lunch_i, single_lunch_i, line1_out_valid_o, line2_out_valid_o);

  assign slot2_addr = tail + PTR_W'(line1_in_valid_i);
  assign head_plus1 = head + PTR_W'(1);

  iq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk    (clk),
    .we0    (push_en & line1_in_valid_i),
    .waddr0 (tail),
    .wdata0 (in_bus_i[ENTRY_W-1:0]),
    .we1    (push_en & line2_in_valid_i),
    .waddr1 (slot2_addr),
    .wdata1 (in_bus_i[BUS_W-1:ENTRY_W]),
    .raddr0 (head),
    .rdata0 (rd_line1),
    .raddr1 (head_plus1),
    .rdata1 (rd_line2)
  );

  // Pointer and occupancy update; a flush discards the same-cycle push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_n);
      tail  <= tail + PTR_W'(push_n);
      count <= count + CNT_W'(push_n) - CNT_W'(pop_n);
    end
  end

  assign line1_out_valid_o = (count != '0);
  assign line2_out_valid_o = (count >= CNT_W'(2));
  assign out_bus_o = {line2_out_valid_o ? rd_line2 : {ENTRY_W{1'b0}},
                      line1_out_valid_o ? rd_line1 : {ENTRY_W{1'b0}}};
  assign count_o   = count;

endmodule
